// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store engine.
//   - SZ_* : request size encodings (byte, halfword, word, reserved)
//   - mau_state_e : FSM state encoding of mem_access_unit
//   - MEM_BYTES_DEFAULT : default data memory size in bytes
//   - size_nbytes() : number of bytes touched by a request size
package mips_mem_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 44;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StStore,
    StDone
  } mau_state_e;

  // Reserved size reports 4 bytes; it is rejected before the range check matters.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    unique case (size)
      SZ_BYTE: size_nbytes = 3'd1;
      SZ_HALF: size_nbytes = 3'd2;
      default: size_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling for sub-word accesses (purely combinational).
// Ports:
//   i_size   : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_offset : byte offset within the word (addr[1:0])
//   i_signed : sign-extend the extracted lane
//   i_word   : full memory word (load data or read-modify-write source)
//   i_wdata  : right-aligned store data
//   o_ext    : extracted and extended lane
//   o_merged : i_word with the addressed lane replaced by i_wdata (i_wdata for words)
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ext,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte offset k lives in bits [31-8k -: 8]; halfword offset 2 is the low half.
  always_comb begin
    w_byte = 8'h00;
    unique case (i_offset)
      2'd0: w_byte = i_word[31:24];
      2'd1: w_byte = i_word[23:16];
      2'd2: w_byte = i_word[15:8];
      2'd3: w_byte = i_word[7:0];
      default: w_byte = 8'h00;
    endcase
    w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
  end

  always_comb begin
    o_ext = i_word;
    case (i_size)
      SZ_BYTE: o_ext = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_ext = {{16{i_signed & w_half[15]}}, w_half};
      default: o_ext = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        unique case (i_offset)
          2'd0: o_merged[31:24] = i_wdata[7:0];
          2'd1: o_merged[23:16] = i_wdata[7:0];
          2'd2: o_merged[15:8]  = i_wdata[7:0];
          2'd3: o_merged[7:0]   = i_wdata[7:0];
          default: o_merged = i_word;
        endcase
      end
      SZ_HALF: begin
        if (i_offset[1]) o_merged[15:0] = i_wdata[15:0];
        else             o_merged[31:16] = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine driving a byte-addressed, big-endian, word-port data memory.
// Ports:
//   clk, rst_n                : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready       : request handshake; accepted when both are high at clk
//   req_write/size/signed/addr/wdata : request fields, latched on acceptance
//   resp_valid/rdata/err      : one-cycle completion pulse with load data and error flag
//   mem_addr/wdata/read/write : word-aligned memory port; mem_rdata is combinational
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  mau_state_e        r_state, w_state_next;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;

  logic [2:0]        w_nbytes;
  logic [ADDR_W:0]   w_limit;
  logic              w_oor;
  logic              w_err;
  logic              w_accept;
  logic [31:0]       w_lane_word;
  logic [31:0]       w_ext;
  logic [31:0]       w_merged;

  // Range check is done one bit wider so addresses near 2^ADDR_W cannot wrap into range.
  always_comb begin
    w_nbytes = size_nbytes(req_size);
    w_limit  = (ADDR_W + 1)'(MEM_BYTES) - (ADDR_W + 1)'(w_nbytes);
    w_oor    = {1'b0, req_addr} > w_limit;
    unique case (req_size)
      SZ_BYTE: w_err = w_oor;
      SZ_HALF: w_err = req_addr[0] | w_oor;
      SZ_WORD: w_err = (req_addr[1:0] != 2'b00) | w_oor;
      default: w_err = 1'b1;
    endcase
  end

  assign w_accept = (r_state == StIdle) && req_valid;

  // The aligner sees the live read word while loading and the merge register otherwise.
  assign w_lane_word = (r_state == StLoad) ? mem_rdata : r_merge;

  mem_lane_align u_lane_align (
    .i_size   (r_size),
    .i_offset (r_addr[1:0]),
    .i_signed (r_signed),
    .i_word   (w_lane_word),
    .i_wdata  (r_wdata),
    .o_ext    (w_ext),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_write  <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_merge  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_err;
        r_rdata  <= '0;
      end
      if (r_state == StLoad)  r_rdata <= w_ext;
      if (r_state == StRmwRd) r_merge <= mem_rdata;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                  w_state_next = StDone;
          else if (!req_write)        w_state_next = StLoad;
          else if (req_size == SZ_WORD) w_state_next = StStore;
          else                        w_state_next = StRmwRd;
        end
      end
      StLoad: begin
        mem_read     = 1'b1;
        mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
        w_state_next = StDone;
      end
      StRmwRd: begin
        mem_read     = 1'b1;
        mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
        w_state_next = StStore;
      end
      StStore: begin
        mem_write    = 1'b1;
        mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
        mem_wdata    = w_merged;
        w_state_next = StDone;
      end
      StDone: begin
        resp_valid   = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign resp_err   = r_err & (r_state == StDone);
  assign resp_rdata = r_rdata;

  // r_write is kept for visibility of the latched request; routing is state-driven.
  logic w_unused;
  assign w_unused = r_write;

endmodule
